// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point adder pipeline.
// The unpacked-operand struct is sized by the package widths below.
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
   localparam int FP_ALN_W = FP_MAN_W + 4;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] eff_exp;
      logic [FP_MAN_W:0]   man;
      logic                is_nan;
      logic                is_inf;
   } fp_unp_t;

   function automatic logic [FP_W-1:0] canon_qnan();
      return {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};
   endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one IEEE-754-style word into sign, effective exponent, mantissa
// with hidden bit, and NaN/Inf flags. Purely combinational.
module fp_unpack
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic [EXP_W+MAN_W:0] word_i,
   input  logic                 neg_i,
   output fp_unp_t              unp_o
);

   logic [EXP_W-1:0] exp_raw;
   logic [MAN_W-1:0] frac;
   logic             exp_zero;
   logic             exp_ones;

   assign exp_raw  = word_i[EXP_W+MAN_W-1:MAN_W];
   assign frac     = word_i[MAN_W-1:0];
   assign exp_zero = (exp_raw == '0);
   assign exp_ones = (exp_raw == {EXP_W{1'b1}});

   // NOTE: every field gets a value on every path, so no latch can be inferred.
   always_comb begin
      unp_o.sign    = word_i[EXP_W+MAN_W] ^ neg_i;
      // Subnormals share the scale of the smallest normal exponent.
      unp_o.eff_exp = exp_zero ? EXP_W'(1) : exp_raw;
      unp_o.man     = {~exp_zero, frac};
      unp_o.is_nan  = exp_ones & (|frac);
      unp_o.is_inf  = exp_ones & ~(|frac);
   end

endmodule

// File: rtl/fp_align_stage.sv
// Front-end of the FP adder: unpack, magnitude ordering, mantissa alignment
// with guard/round/sticky, and NaN/Inf detection behind a valid/ready register.
module fp_align_stage
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W,
   localparam int W     = 1 + EXP_W + MAN_W,
   localparam int ALN_W = MAN_W + 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             big_sign,
   output logic             eff_sub,
   output logic             swapped,
   output logic [EXP_W-1:0] big_exp,
   output logic [EXP_W-1:0] exp_diff,
   output logic [MAN_W:0]   big_man,
   output logic [ALN_W-1:0] small_aln,
   output logic             special,
   output logic [W-1:0]     special_word
);

   typedef struct packed {
      logic             big_sign;
      logic             eff_sub;
      logic             swapped;
      logic [EXP_W-1:0] big_exp;
      logic [EXP_W-1:0] exp_diff;
      logic [MAN_W:0]   big_man;
      logic [ALN_W-1:0] small_aln;
      logic             special;
      logic [W-1:0]     special_word;
   } stage_t;

   fp_unp_t unp_a;
   fp_unp_t unp_b;

   stage_t res_d;
   stage_t res_q;
   logic   out_valid_q;

   logic             a_big;
   logic [EXP_W-1:0] sml_exp;
   logic [MAN_W:0]   sml_man;
   logic [EXP_W-1:0] diff;
   logic [ALN_W-1:0] aln_full;
   logic [ALN_W-1:0] lost_mask;
   logic [ALN_W-1:0] shifted;

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .word_i (a),
      .neg_i  (1'b0),
      .unp_o  (unp_a)
   );

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .word_i (b),
      .neg_i  (op),
      .unp_o  (unp_b)
   );

   always_comb begin
      res_d     = '0;
      shifted   = '0;

      // Full magnitude compare, so equal exponents still order by fraction.
      a_big     = (a[W-2:0] >= b[W-2:0]);
      sml_exp   = a_big ? unp_b.eff_exp : unp_a.eff_exp;
      sml_man   = a_big ? unp_b.man     : unp_a.man;

      res_d.swapped  = ~a_big;
      res_d.big_sign = a_big ? unp_a.sign    : unp_b.sign;
      res_d.big_exp  = a_big ? unp_a.eff_exp : unp_b.eff_exp;
      res_d.big_man  = a_big ? unp_a.man     : unp_b.man;
      res_d.eff_sub  = unp_a.sign ^ unp_b.sign;

      diff           = res_d.big_exp - sml_exp;
      res_d.exp_diff = diff;

      aln_full  = {sml_man, 3'b000};
      lost_mask = ~({ALN_W{1'b1}} << diff);
      if (int'(diff) >= ALN_W) begin
         res_d.small_aln = {{(ALN_W-1){1'b0}}, |sml_man};
      end else begin
         shifted         = aln_full >> diff;
         res_d.small_aln = {shifted[ALN_W-1:1], shifted[0] | (|(aln_full & lost_mask))};
      end

      if (unp_a.is_nan || unp_b.is_nan || (unp_a.is_inf && unp_b.is_inf && res_d.eff_sub)) begin
         res_d.special      = 1'b1;
         res_d.special_word = canon_qnan();
      end else if (unp_a.is_inf) begin
         res_d.special      = 1'b1;
         res_d.special_word = {unp_a.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (unp_b.is_inf) begin
         res_d.special      = 1'b1;
         res_d.special_word = {unp_b.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   assign in_ready = ~out_valid_q | out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
      end else if (in_ready) begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            res_q <= res_d;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign big_sign     = res_q.big_sign;
   assign eff_sub      = res_q.eff_sub;
   assign swapped      = res_q.swapped;
   assign big_exp      = res_q.big_exp;
   assign exp_diff     = res_q.exp_diff;
   assign big_man      = res_q.big_man;
   assign small_aln    = res_q.small_aln;
   assign special      = res_q.special;
   assign special_word = res_q.special_word;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed and randomized bench for fp_align_stage, checked against an
// arithmetic reference model and a one-deep expected-output queue.
module tb_fp_align_stage;

   localparam int EW = 8;
   localparam int MW = 23;
   localparam int W  = 1 + EW + MW;
   localparam int AW = MW + 4;

   typedef struct {
      logic          big_sign;
      logic          eff_sub;
      logic          swapped;
      logic [EW-1:0] big_exp;
      logic [EW-1:0] exp_diff;
      logic [MW:0]   big_man;
      logic [AW-1:0] small_aln;
      logic          special;
      logic [W-1:0]  special_word;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          op;
   logic          out_valid;
   logic          out_ready;
   logic          big_sign;
   logic          eff_sub;
   logic          swapped;
   logic [EW-1:0] big_exp;
   logic [EW-1:0] exp_diff;
   logic [MW:0]   big_man;
   logic [AW-1:0] small_aln;
   logic          special;
   logic [W-1:0]  special_word;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   fp_align_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a            (a),
      .b            (b),
      .op           (op),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .big_sign     (big_sign),
      .eff_sub      (eff_sub),
      .swapped      (swapped),
      .big_exp      (big_exp),
      .exp_diff     (exp_diff),
      .big_man      (big_man),
      .small_aln    (small_aln),
      .special      (special),
      .special_word (special_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv);
      exp_t            r;
      int unsigned     ea, eb, fa, fb, eea, eeb, ebig, esml, d;
      longint unsigned ma, mb, msml, s, sh, lost;
      logic            sa, sb, nan_a, nan_b, inf_a, inf_b;
      sa  = av[W-1];
      sb  = bv[W-1] ^ opv;
      ea  = int'(av[W-2:MW]);
      eb  = int'(bv[W-2:MW]);
      fa  = int'(av[MW-1:0]);
      fb  = int'(bv[MW-1:0]);
      eea = (ea == 0) ? 1 : ea;
      eeb = (eb == 0) ? 1 : eb;
      ma  = longint'(fa) + ((ea != 0) ? (64'd1 << MW) : 64'd0);
      mb  = longint'(fb) + ((eb != 0) ? (64'd1 << MW) : 64'd0);
      r.swapped  = (ea * (2 ** MW) + fa) < (eb * (2 ** MW) + fb);
      r.eff_sub  = sa ^ sb;
      r.big_sign = r.swapped ? sb : sa;
      ebig       = r.swapped ? eeb : eea;
      esml       = r.swapped ? eea : eeb;
      r.big_man  = (MW+1)'(r.swapped ? mb : ma);
      msml       = r.swapped ? ma : mb;
      r.big_exp  = EW'(ebig);
      d          = ebig - esml;
      r.exp_diff = EW'(d);
      s          = msml * 8;
      if (d >= AW) begin
         r.small_aln = AW'(msml != 0);
      end else begin
         sh          = s / (64'd1 << d);
         lost        = s % (64'd1 << d);
         r.small_aln = AW'(sh | longint'(lost != 0));
      end
      nan_a = (ea == 255) && (fa != 0);
      nan_b = (eb == 255) && (fb != 0);
      inf_a = (ea == 255) && (fa == 0);
      inf_b = (eb == 255) && (fb == 0);
      r.special      = 1'b1;
      if (nan_a || nan_b || (inf_a && inf_b && r.eff_sub)) r.special_word = 32'h7FC0_0000;
      else if (inf_a) r.special_word = {sa, 31'h7F80_0000};
      else if (inf_b) r.special_word = {sb, 31'h7F80_0000};
      else begin
         r.special      = 1'b0;
         r.special_word = '0;
      end
      return r;
   endfunction

   task automatic check_out(input string tag, input exp_t e);
      check({tag, ".big_sign"}, 64'(big_sign), 64'(e.big_sign));
      check({tag, ".eff_sub"}, 64'(eff_sub), 64'(e.eff_sub));
      check({tag, ".swapped"}, 64'(swapped), 64'(e.swapped));
      check({tag, ".big_exp"}, 64'(big_exp), 64'(e.big_exp));
      check({tag, ".exp_diff"}, 64'(exp_diff), 64'(e.exp_diff));
      check({tag, ".big_man"}, 64'(big_man), 64'(e.big_man));
      check({tag, ".small_aln"}, 64'(small_aln), 64'(e.small_aln));
      check({tag, ".special"}, 64'(special), 64'(e.special));
      check({tag, ".special_word"}, 64'(special_word), 64'(e.special_word));
   endtask

   // One clock of traffic: drive, check ready, clock, update queue, check outputs.
   task automatic cycle(input string tag, input logic iv, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic opv, input logic ordy);
      logic rdy_m, acc, pop;
      @(negedge clk);
      in_valid  = iv;
      a         = av;
      b         = bv;
      op        = opv;
      out_ready = ordy;
      #1;
      rdy_m = (exp_q.size() == 0) || ordy;
      check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy_m));
      acc = iv && rdy_m;
      pop = (exp_q.size() != 0) && ordy;
      @(posedge clk);
      #1;
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model(av, bv, opv));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) check_out(tag, exp_q[0]);
   endtask

   task automatic do_reset(input string tag);
      exp_t z;
      z = '{default: '0};
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = $urandom;
      b         = $urandom;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
      check_out(tag, z);
      exp_q.delete();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [EW-1:0] e;
      logic [MW-1:0] f;
      case ($urandom_range(0, 7))
         0:       e = '0;
         1:       e = '1;
         default: e = EW'($urandom_range(100, 150));
      endcase
      f = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom);
      return {1'($urandom), e, f};
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      do_reset("reset");

      cycle("basic", 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1);
      check("basic.lit_diff", 64'(exp_diff), 64'd1);
      check("basic.lit_aln", 64'(small_aln), 64'h200_0000);
      check("basic.lit_swapped", 64'(swapped), 64'd1);
      cycle("sticky_in", 1'b1, 32'h4B80_0000, 32'h3F80_0001, 1'b0, 1'b1);
      check("sticky_in.lit_aln", 64'(small_aln), 64'h5);
      check("sticky_in.lit_diff", 64'(exp_diff), 64'd24);
      cycle("sticky_out", 1'b1, 32'h4F80_0000, 32'h3F80_0000, 1'b0, 1'b1);
      check("sticky_out.lit_aln", 64'(small_aln), 64'h1);
      cycle("subnorm", 1'b1, 32'h0000_0001, 32'h0080_0000, 1'b0, 1'b1);
      check("subnorm.lit_aln", 64'(small_aln), 64'h8);
      cycle("equal", 1'b1, 32'h4040_0000, 32'h4040_0000, 1'b1, 1'b1);
      check("equal.lit_swapped", 64'(swapped), 64'd0);
      cycle("inf_sub_inf", 1'b1, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b1);
      check("inf_sub_inf.lit_word", 64'(special_word), 64'h7FC0_0000);
      cycle("nan_a", 1'b1, 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b1);
      check("nan_a.lit_word", 64'(special_word), 64'h7FC0_0000);
      cycle("inf_a", 1'b1, 32'h7F80_0000, 32'h3F80_0000, 1'b1, 1'b1);
      check("inf_a.lit_word", 64'(special_word), 64'h7F80_0000);
      cycle("neg_inf", 1'b1, 32'hFF80_0000, 32'h7F80_0000, 1'b1, 1'b1);
      check("neg_inf.lit_word", 64'(special_word), 64'hFF80_0000);
      cycle("zeros", 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
      cycle("drain", 1'b0, '0, '0, 1'b0, 1'b1);

      cycle("bp_item1", 1'b1, 32'h4120_0000, 32'h3F00_0000, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle("bp_hold", 1'b1, 32'hC2C8_0000, 32'h4348_0000, 1'b1, 1'b0);
      end
      cycle("bp_item2", 1'b1, 32'hC2C8_0000, 32'h4348_0000, 1'b1, 1'b1);
      cycle("bp_drain", 1'b0, '0, '0, 1'b0, 1'b1);

      cycle("pre_rst", 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
      do_reset("mid_rst");
      cycle("post_rst", 1'b1, 32'h4000_0000, 32'h3F80_0000, 1'b1, 1'b1);

      for (int i = 0; i < 300; i++) begin
         cycle("rand", 1'($urandom_range(0, 3) != 0), rand_word(), rand_word(),
               1'($urandom), 1'($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
